// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the data_ram arbiter: owner states, read-owner tags, bus widths.
package dram_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BSEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CPU       = 2'd1,
    ST_DMA_BURST = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for burst beats and DMA starvation.
module arb_sat_cnt #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Per-cycle arbiter sharing single-port data_ram between the CPU data port and a DMA master.
// Optional DRAM_ARB_STATS_EN adds stall-cycle and DMA-beat counters.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 11,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              cpu_ce,
  input  logic [BSEL_W-1:0] cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [BSEL_W-1:0] dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [DATA_W-1:0] dma_din,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_dout,
  output logic              ram_ce,
  output logic [BSEL_W-1:0] ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_stall,
  output logic [31:0]       stat_dma_beats
`endif
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  state_t            state;
  logic [BW-1:0]     beat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              cpu_gnt;
  logic              in_burst;
  logic              lock_ok;
  logic              beat_full;
  logic              starve;
  logic              rd_owner;
  logic              rd_pend;
  logic [DATA_W-1:0] cpu_hold;
  logic              unused_addr;

  assign in_burst  = (state == ST_DMA_BURST);
  assign lock_ok   = dma_req && dma_lock;
  assign beat_full = (beat_cnt == BW'(MAX_BURST));
  assign starve    = (starve_cnt == SW'(STARVE_LIMIT));

  // Grant: burst owner first (one CPU slot when the burst is full), else CPU unless DMA starved.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!cpu_rst) begin
      if (in_burst && lock_ok) begin
        if (beat_full && cpu_ce) cpu_gnt = 1'b1;
        else                     dma_gnt = 1'b1;
      end else if (dma_req && (!cpu_ce || starve)) begin
        dma_gnt = 1'b1;
      end else if (cpu_ce) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_ce && !cpu_gnt && !cpu_rst;
  assign ram_ce    = cpu_gnt || dma_gnt;
  assign ram_we    = dma_gnt ? dma_we : (cpu_gnt ? cpu_we : '0);
  assign ram_addr  = dma_gnt ? dma_addr[AW+1:2] : cpu_addr[AW+1:2];
  assign ram_din   = dma_gnt ? dma_din : cpu_din;
  assign dma_dout  = ram_dout;
  assign cpu_dout  = (rd_pend && (rd_owner == OWN_CPU)) ? ram_dout : cpu_hold;

  assign unused_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0], dma_addr[31:AW+2], dma_addr[1:0]};

  arb_sat_cnt #(.W(BW), .LIMIT(MAX_BURST)) u_beat_cnt (
    .clk (cpu_clk_50M),
    .rst (cpu_rst),
    .inc (dma_gnt && dma_lock),
    .clr (in_burst && (beat_full || !lock_ok)),
    .cnt (beat_cnt)
  );

  arb_sat_cnt #(.W(SW), .LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk (cpu_clk_50M),
    .rst (cpu_rst),
    .inc (dma_req && !dma_gnt),
    .clr (dma_gnt),
    .cnt (starve_cnt)
  );

  // Owner FSM: a locked DMA grant opens a burst that lasts while the lock is held.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_DMA_BURST: if (!lock_ok) state <= ST_IDLE;
        default: begin
          if (dma_gnt && dma_lock) state <= ST_DMA_BURST;
          else if (cpu_gnt)        state <= ST_CPU;
          else                     state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data steering: tag the owner of the read issued this cycle.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      rd_owner   <= OWN_CPU;
      rd_pend    <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_hold   <= '0;
    end else begin
      rd_pend    <= (cpu_gnt && (cpu_we == '0)) || (dma_gnt && (dma_we == '0));
      dma_rvalid <= dma_gnt && (dma_we == '0);
      cpu_hold   <= cpu_dout;
      if (ram_ce && (ram_we == '0)) rd_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
    end
  end

`ifdef DRAM_ARB_STATS_EN
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      stat_cpu_stall <= '0;
      stat_dma_beats <= '0;
    end else begin
      if (cpu_stall) stat_cpu_stall <= stat_cpu_stall + 32'd1;
      if (dma_gnt)   stat_dma_beats <= stat_dma_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural 1-cycle BRAM model.
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        cpu_ce;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic        dma_req, dma_lock;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr, dma_din;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_dout;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall, stat_dma_beats;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  dram_arbiter dut (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
`ifdef DRAM_ARB_STATS_EN
    , .stat_cpu_stall(stat_cpu_stall), .stat_dma_beats(stat_dma_beats)
`endif
  );

  // Read-first BRAM model with byte enables
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  task automatic idle_inputs();
    cpu_ce = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = '0;
    dma_req = 1'b0; dma_lock = 1'b0; dma_we = 4'h0; dma_addr = '0; dma_din = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    cpu_rst = 1'b1;
    @(negedge clk);
    cpu_rst = 1'b0;
    cpu_q.delete();
    dma_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_rst = 1'b1; cpu_ce = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'hF; dma_addr = 32'h200;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", cpu_stall); end
    checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL reset_dma_gnt got=%0b exp=0", dma_gnt); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL reset_ram_ce got=%0b exp=0", ram_ce); end
    @(negedge clk);
    #1;
    checks++; if (cpu_dout !== 32'h0) begin failures++; $display("FAIL reset_cpu_dout got=%h exp=0", cpu_dout); end
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", dma_rvalid); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    cpu_rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_cpu_only();
    logic [31:0] exp;
    apply_reset();
    @(negedge clk);
    cpu_ce = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h100; cpu_din = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_wr_stall got=%0b exp=0", cpu_stall); end
    checks++; if ({ram_ce, ram_we, ram_addr} !== {1'b1, 4'hF, 11'h040}) begin
      failures++; $display("FAIL cpu_wr_ram got=%b/%h/%h exp=1/f/040", ram_ce, ram_we, ram_addr); end
    checks++; if (ram_din !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_wr_din got=%h exp=deadbeef", ram_din); end
    @(negedge clk);
    cpu_we = 4'h0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_rd_stall got=%0b exp=0", cpu_stall); end
    cpu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_idle_stall got=%0b exp=0", cpu_stall); end
    exp = cpu_q.pop_front();
    checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL cpu_rd_data got=%h exp=%h", cpu_dout, exp); end
    @(negedge clk);
    #1;
    checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL cpu_dout_hold got=%h exp=%h", cpu_dout, exp); end
  endtask

  task automatic test_conflict();
    logic [31:0] exp;
    apply_reset();
    @(negedge clk);
    cpu_ce = 1'b1; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_addr = 32'h200;
    #1;
    checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL conflict_dma_gnt got=%0b exp=0", dma_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL conflict_stall got=%0b exp=0", cpu_stall); end
    checks++; if (ram_addr !== 11'h040) begin failures++; $display("FAIL conflict_addr got=%h exp=040", ram_addr); end
    cpu_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (dut.starve_cnt !== 5'd1) begin failures++; $display("FAIL conflict_starve got=%0d exp=1", dut.starve_cnt); end
    exp = cpu_q.pop_front();
    checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL conflict_cpu_dout got=%h exp=%h", cpu_dout, exp); end
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL conflict_rvalid got=%0b exp=0", dma_rvalid); end
  endtask

  task automatic test_starvation();
    logic cpu_pend;
    logic exp_g;
    logic [31:0] exp;
    apply_reset();
    cpu_pend = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      cpu_ce = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h100;
      dma_req = 1'b1; dma_we = 4'hF; dma_addr = 32'h300; dma_din = 32'h12345678;
      #1;
      if (cpu_pend) begin
        exp = cpu_q.pop_front();
        checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL starve_cpu_dout k=%0d got=%h exp=%h", k, cpu_dout, exp); end
      end
      exp_g = (k == 17);
      checks++; if (dma_gnt !== exp_g) begin failures++; $display("FAIL starve_dma_gnt k=%0d got=%0b exp=%0b", k, dma_gnt, exp_g); end
      checks++; if (cpu_stall !== exp_g) begin failures++; $display("FAIL starve_stall k=%0d got=%0b exp=%0b", k, cpu_stall, exp_g); end
      if (exp_g) begin
        checks++; if ({ram_addr, ram_din} !== {11'h0C0, 32'h12345678}) begin
          failures++; $display("FAIL starve_dma_wr got=%h/%h exp=0c0/12345678", ram_addr, ram_din); end
      end
      cpu_pend = !exp_g;
      if (cpu_pend) cpu_q.push_back(32'hDEADBEEF);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    if (cpu_pend) begin
      exp = cpu_q.pop_front();
      checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL starve_last_dout got=%h exp=%h", cpu_dout, exp); end
    end
  endtask

  task automatic test_burst();
    int beat;
    int cyc;
    logic exp_d, exp_s, cpu_pend;
    logic [31:0] exp;
    apply_reset();
    beat = 0; cyc = 0; cpu_pend = 1'b0;
    while (beat < 10 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      cpu_ce = (cyc >= 2); cpu_we = 4'h0; cpu_addr = 32'h100;
      dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'hF;
      dma_addr = 32'h400 + 32'(4 * beat); dma_din = 32'hB000_0000 | 32'(beat);
      #1;
      if (cpu_pend) begin
        exp = cpu_q.pop_front();
        checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL burst_cpu_dout c=%0d got=%h exp=%h", cyc, cpu_dout, exp); end
      end
      exp_d = (cyc != 9);
      exp_s = cpu_ce && !exp_d;
      exp_s = cpu_ce && exp_d;
      checks++; if (dma_gnt !== exp_d) begin failures++; $display("FAIL burst_dma_gnt c=%0d got=%0b exp=%0b", cyc, dma_gnt, exp_d); end
      checks++; if (cpu_stall !== exp_s) begin failures++; $display("FAIL burst_stall c=%0d got=%0b exp=%0b", cyc, cpu_stall, exp_s); end
      cpu_pend = cpu_ce && !exp_d;
      if (cpu_pend) cpu_q.push_back(32'hDEADBEEF);
      if (dma_gnt) begin
        checks++; if (ram_din !== (32'hB000_0000 | 32'(beat))) begin
          failures++; $display("FAIL burst_din c=%0d got=%h exp=%h", cyc, ram_din, 32'hB000_0000 | 32'(beat)); end
        beat++;
      end
    end
    checks++; if (beat != 10 || cyc != 11) begin failures++; $display("FAIL burst_length got beats=%0d cycles=%0d exp beats=10 cycles=11", beat, cyc); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_read_steer();
    logic [31:0] exp;
    apply_reset();
    @(negedge clk);
    cpu_ce = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h40; cpu_din = 32'hA5A5_0040;
    @(negedge clk);
    cpu_addr = 32'h44; cpu_din = 32'h5A5A_0044;
    @(negedge clk);
    idle_inputs();
    dma_req = 1'b1; dma_addr = 32'h40;
    #1;
    checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL steer_dma_gnt got=%0b exp=1", dma_gnt); end
    dma_q.push_back(32'hA5A5_0040);
    @(negedge clk);
    dma_req = 1'b0;
    cpu_ce = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h44;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL steer_cpu_stall got=%0b exp=0", cpu_stall); end
    checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL steer_rvalid got=%0b exp=1", dma_rvalid); end
    exp = dma_q.pop_front();
    checks++; if (dma_dout !== exp) begin failures++; $display("FAIL steer_dma_dout got=%h exp=%h", dma_dout, exp); end
    checks++; if (cpu_dout !== 32'h0) begin failures++; $display("FAIL steer_cpu_held got=%h exp=0", cpu_dout); end
    cpu_q.push_back(32'h5A5A_0044);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL steer_rvalid_drop got=%0b exp=0", dma_rvalid); end
    exp = cpu_q.pop_front();
    checks++; if (cpu_dout !== exp) begin failures++; $display("FAIL steer_cpu_dout got=%h exp=%h", cpu_dout, exp); end
  endtask

  task automatic test_reset_burst();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'h0; dma_addr = 32'h400 + 32'(4 * c);
      #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL rb_beat_gnt c=%0d got=%0b exp=1", c, dma_gnt); end
    end
    @(negedge clk);
    cpu_rst = 1'b1; cpu_ce = 1'b1; dma_we = 4'hF; dma_addr = 32'h400; dma_din = 32'hFFFF_FFFF;
    #1;
    checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rb_rst_gnt got=%0b exp=0", dma_gnt); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL rb_rst_ram_ce got=%0b exp=0", ram_ce); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rb_rst_stall got=%0b exp=0", cpu_stall); end
    @(negedge clk);
    cpu_rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rb_rvalid got=%0b exp=0", dma_rvalid); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL rb_ram_ce got=%0b exp=0", ram_ce); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rb_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    checks++; if (dut.beat_cnt !== '0) begin failures++; $display("FAIL rb_beat_cnt got=%0d exp=0", dut.beat_cnt); end
    checks++; if (mem[11'h100] !== 32'hB000_0000) begin failures++; $display("FAIL rb_no_write got=%h exp=b0000000", mem[11'h100]); end
`ifdef DRAM_ARB_STATS_EN
    checks++; if ({stat_cpu_stall, stat_dma_beats} !== 64'h0) begin
      failures++; $display("FAIL rb_stats got=%0d/%0d exp=0/0", stat_cpu_stall, stat_dma_beats); end
`endif
    @(negedge clk);
    cpu_ce = 1'b1; cpu_addr = 32'h100; dma_req = 1'b1; dma_addr = 32'h400;
    #1;
    checks++; if ({cpu_stall, dma_gnt} !== 2'b00) begin failures++; $display("FAIL rb_rearb got=%b exp=00", {cpu_stall, dma_gnt}); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    ram_dout = 32'h0;
    cpu_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_conflict();
    test_starvation();
    test_burst();
    test_read_steer();
    test_reset_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
